// File: rtl/wf_issue_scheduler.sv
// Round-robin issue scheduler for 40 wavefront slots.
// Registered valid/ready offer, pending tracking and in-flight cap.
module wf_issue_scheduler #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] ready_arry,
  input  logic        fu_ready,
  input  logic        done_en,
  input  logic [5:0]  done_wf_id,
  output logic        issue_valid,
  output logic [5:0]  issue_wf_id,
  output logic [39:0] pending_arry,
  output logic [3:0]  outstanding_cnt,
  output logic        err_spurious_done
);

  localparam int NWF = 40;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  logic [0:0]  state;
  logic [5:0]  last_issued;
  logic        accept;
  logic [39:0] acc_oh;
  logic        done_ok;
  logic [39:0] done_oh;
  logic [39:0] cand;
  logic [5:0]  ptr;
  logic        room;
  logic [6:0]  pick;
  logic        sel_valid;

  // Lowest offset from ptr+1 (mod 40) wins; bit 6 flags a hit.
  function automatic logic [6:0] rr_pick(
    input logic [39:0] c,
    input logic [5:0]  p
  );
    logic [6:0] r;
    logic [5:0] i6;
    int         idx;
    r = '0;
    for (int k = NWF - 1; k >= 0; k--) begin
      idx = (int'(p) + 1 + k) % NWF;
      i6  = idx[5:0];
      if (c[i6]) r = {1'b1, i6};
    end
    return r;
  endfunction

  assign issue_valid = (state == OFFER);
  assign accept      = issue_valid & fu_ready;
  assign acc_oh      = 40'd1 << issue_wf_id;

  always_comb begin
    done_ok = 1'b0;
    done_oh = '0;
    if (done_en && done_wf_id < 6'd40) begin
      done_ok = pending_arry[done_wf_id];
      if (done_ok) done_oh = 40'd1 << done_wf_id;
    end
  end

  // On accept, reselect as if the accepted id were already pending.
  always_comb begin
    cand = ready_arry & ~pending_arry;
    ptr  = last_issued;
    room = {1'b0, outstanding_cnt} < 5'(MAX_OUTSTANDING);
    if (state == OFFER) begin
      cand = ready_arry & ~pending_arry & ~acc_oh;
      ptr  = issue_wf_id;
      room = ({1'b0, outstanding_cnt} + 5'd1) < 5'(MAX_OUTSTANDING);
    end
  end

  assign pick      = rr_pick(cand, ptr);
  assign sel_valid = room & pick[6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      issue_wf_id       <= '0;
      last_issued       <= 6'd39;
      pending_arry      <= '0;
      outstanding_cnt   <= '0;
      err_spurious_done <= 1'b0;
    end else begin
      pending_arry <= (pending_arry | (accept ? acc_oh : 40'd0)) & ~done_oh;
      outstanding_cnt <= outstanding_cnt + {3'd0, accept}
                         - {3'd0, done_ok};
      if (done_en && !done_ok) err_spurious_done <= 1'b1;
      if (accept) last_issued <= issue_wf_id;
      if (state == IDLE || accept) begin
        if (sel_valid) begin
          issue_wf_id <= pick[5:0];
          state       <= OFFER;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_wf_issue_scheduler.sv
// Directed bench for wf_issue_scheduler.
// Vector table plus hand-written multi-cycle sequences.
module tb_wf_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] ready_arry;
  logic        fu_ready;
  logic        done_en;
  logic [5:0]  done_wf_id;
  logic        issue_valid;
  logic [5:0]  issue_wf_id;
  logic [39:0] pending_arry;
  logic [3:0]  outstanding_cnt;
  logic        err_spurious_done;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [39:0] ALL = 40'hFF_FFFF_FFFF;

  wf_issue_scheduler #(.MAX_OUTSTANDING(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .ready_arry        (ready_arry),
    .fu_ready          (fu_ready),
    .done_en           (done_en),
    .done_wf_id        (done_wf_id),
    .issue_valid       (issue_valid),
    .issue_wf_id       (issue_wf_id),
    .pending_arry      (pending_arry),
    .outstanding_cnt   (outstanding_cnt),
    .err_spurious_done (err_spurious_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rb;
    logic [39:0] ready;
    logic        fu;
    logic        den;
    logic [5:0]  did;
    logic        ev;
    logic [5:0]  eid;
    logic [39:0] ep;
    logic [3:0]  ec;
    logic        ee;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input string nm, input logic rb, input logic [39:0] r,
    input logic f, input logic de, input logic [5:0] di,
    input logic ev, input logic [5:0] eid, input logic [39:0] ep,
    input logic [3:0] ec, input logic ee
  );
    vec_t v;
    v.nm = nm; v.rb = rb; v.ready = r; v.fu = f;
    v.den = de; v.did = di; v.ev = ev; v.eid = eid;
    v.ep = ep; v.ec = ec; v.ee = ee;
    tbl.push_back(v);
  endtask

  task automatic chk(
    input string nm, input logic ev, input logic [5:0] eid,
    input logic [39:0] ep, input logic [3:0] ec, input logic ee
  );
    n_cmp++;
    if ({issue_valid, issue_wf_id, pending_arry, outstanding_cnt,
         err_spurious_done} !== {ev, eid, ep, ec, ee}) begin
      n_bad++;
      $display("FAIL %s: got v=%0b id=%0d pend=%h cnt=%0d err=%0b, want v=%0b id=%0d pend=%h cnt=%0d err=%0b",
               nm, issue_valid, issue_wf_id, pending_arry,
               outstanding_cnt, err_spurious_done,
               ev, eid, ep, ec, ee);
    end
  endtask

  task automatic step(
    input logic [39:0] r, input logic f,
    input logic de, input logic [5:0] di
  );
    ready_arry = r;
    fu_ready   = f;
    done_en    = de;
    done_wf_id = di;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    ready_arry = '0;
    fu_ready   = 1'b0;
    done_en    = 1'b0;
    done_wf_id = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // single issue, no reissue, reissue after done
    add("a_offer0",   1, 40'h1, 1, 0, 0,  1, 0, 40'h0, 0, 0);
    add("a_acc0",     0, 40'h1, 1, 0, 0,  0, 0, 40'h1, 1, 0);
    add("a_noreiss",  0, 40'h1, 1, 0, 0,  0, 0, 40'h1, 1, 0);
    add("a_done0",    0, 40'h1, 1, 1, 0,  0, 0, 40'h0, 0, 0);
    add("a_reoffer0", 0, 40'h1, 1, 0, 0,  1, 0, 40'h0, 0, 0);
    // back-to-back until the cap, then refill after a done
    add("b_offer0", 1, ALL, 1, 0, 0,  1, 0, 40'h0,  0, 0);
    add("b_acc0",   0, ALL, 1, 0, 0,  1, 1, 40'h1,  1, 0);
    add("b_acc1",   0, ALL, 1, 0, 0,  1, 2, 40'h3,  2, 0);
    add("b_acc2",   0, ALL, 1, 0, 0,  1, 3, 40'h7,  3, 0);
    add("b_acc3",   0, ALL, 1, 0, 0,  1, 4, 40'hF,  4, 0);
    add("b_acc4",   0, ALL, 1, 0, 0,  1, 5, 40'h1F, 5, 0);
    add("b_acc5",   0, ALL, 1, 0, 0,  1, 6, 40'h3F, 6, 0);
    add("b_acc6",   0, ALL, 1, 0, 0,  1, 7, 40'h7F, 7, 0);
    add("b_acc7",   0, ALL, 1, 0, 0,  0, 7, 40'hFF, 8, 0);
    add("b_full",   0, ALL, 1, 0, 0,  0, 7, 40'hFF, 8, 0);
    add("b_done3",  0, ALL, 1, 1, 3,  0, 7, 40'hF7, 7, 0);
    add("b_offer8", 0, ALL, 1, 0, 0,  1, 8, 40'hF7, 7, 0);
    add("b_acc8",   0, ALL, 1, 0, 0,  0, 8, 40'h1F7, 8, 0);
    // spurious and legal completions
    add("s_done10", 0, 40'h0, 0, 1, 10, 0, 8, 40'h1F7, 8, 1);
    add("s_done2",  0, 40'h0, 0, 1, 2,  0, 8, 40'h1F3, 7, 1);
    add("s_done45", 1, 40'h0, 0, 1, 45, 0, 0, 40'h0,   0, 1);

    do_reset();
    chk("reset", 0, 0, 40'h0, 0, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rb) do_reset();
      step(tbl[i].ready, tbl[i].fu, tbl[i].den, tbl[i].did);
      chk(tbl[i].nm, tbl[i].ev, tbl[i].eid, tbl[i].ep,
          tbl[i].ec, tbl[i].ee);
    end

    // hold: offer stays while fu_ready low and ready drops
    do_reset();
    step(40'h20, 0, 0, 0);
    chk("h_offer5", 1, 5, 40'h0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(40'h0, 0, 0, 0);
      chk("h_hold5", 1, 5, 40'h0, 0, 0);
    end
    step(40'h0, 1, 0, 0);
    chk("h_acc5", 0, 5, 40'h20, 1, 0);

    // wrap: last_issued 38, cand {2,39}
    do_reset();
    step(40'h40_0000_0000, 1, 0, 0);
    chk("w_offer38", 1, 38, 40'h0, 0, 0);
    step(40'h40_0000_0000, 1, 0, 0);
    chk("w_acc38", 0, 38, 40'h40_0000_0000, 1, 0);
    step(40'h0, 0, 1, 38);
    chk("w_done38", 0, 38, 40'h0, 0, 0);
    step(40'h80_0000_0004, 0, 0, 0);
    chk("w_offer39", 1, 39, 40'h0, 0, 0);
    step(40'h80_0000_0004, 1, 0, 0);
    chk("w_offer2", 1, 2, 40'h80_0000_0000, 1, 0);
    step(40'h80_0000_0004, 1, 0, 0);
    chk("w_acc2", 0, 2, 40'h80_0000_0004, 2, 0);

    // simultaneous accept and done
    do_reset();
    step(40'h7, 1, 0, 0);
    chk("x_offer0", 1, 0, 40'h0, 0, 0);
    step(40'h7, 1, 0, 0);
    step(40'h7, 1, 0, 0);
    step(40'h7, 1, 0, 0);
    chk("x_cnt3", 0, 2, 40'h7, 3, 0);
    step(40'h10, 0, 0, 0);
    chk("x_offer4", 1, 4, 40'h7, 3, 0);
    step(40'h10, 1, 1, 1);
    chk("x_acc4_done1", 0, 4, 40'h15, 3, 0);
    step(40'h40, 0, 0, 0);
    chk("x_offer6", 1, 6, 40'h15, 3, 0);
    step(40'h40, 1, 1, 6);
    chk("x_same_id", 0, 6, 40'h55, 4, 1);
    step(40'h200, 0, 0, 0);
    chk("x_offer9", 1, 9, 40'h55, 4, 1);

    // asynchronous reset mid-offer, no clock edge in between
    #2;
    rst = 1'b1;
    #1;
    chk("r_async", 0, 0, 40'h0, 0, 0);
    #2;
    rst = 1'b0;
    step(40'h0, 0, 0, 0);
    chk("r_after", 0, 0, 40'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wf_issue_scheduler.md
# wf_issue_scheduler

Round-robin issue scheduler that shares one functional-unit issue port among 40 wavefront slots. Each cycle it selects an eligible, non-pending wavefront fairly, starting after the most recently issued one. It presents that wavefront on a registered valid/ready handshake and marks it pending until the unit reports completion. It also caps the number of in-flight issues, and sits between the per-wavefront readiness logic and the execution unit in the issue stage.

## Interface
- MAX_OUTSTANDING, 8: maximum accepted-but-not-completed issues; legal range 1..15.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ready_arry  input  40  bit i = wavefront i eligible to issue.
- fu_ready  input  1  functional unit accepts the offered wavefront this cycle.
- done_en  input  1  completion report valid.
- done_wf_id  input  6  completed wavefront id.
- issue_valid  output  1  offer valid, registered.
- issue_wf_id  output  6  offered wavefront id, registered.
- pending_arry  output  40  bit i = wavefront i issued and not yet completed.
- outstanding_cnt  output  4  number of set bits in pending_arry.
- err_spurious_done  output  1  sticky; a done arrived for a non-pending or out-of-range id.

## Operation
- Candidates: `cand = ready_arry & ~pending_arry`. A new selection is allowed only when `outstanding_cnt < MAX_OUTSTANDING`.
- Round-robin search: scan from `(last_issued + 1) mod 40` upward, wrapping 39→0. The first set candidate bit wins. `last_issued` is internal, 6 bits, and resets to 39, so the first search starts at 0.
- Two states:
  - IDLE: `issue_valid` = 0. If a selection is allowed and cand is non-zero, register the winner into `issue_wf_id`, set `issue_valid`, and go to OFFER. Otherwise stay in IDLE.
  - OFFER: `issue_valid` = 1 and `issue_wf_id` holds stable until accepted. The offer is committed: a falling `ready_arry` bit does not withdraw it. Acceptance occurs on a cycle with `fu_ready` = 1.
- On accept:
  - Set `pending[issue_wf_id]`.
  - Set `last_issued <= issue_wf_id`.
  - Increment the count.
  - Same-cycle reselection: recompute with the accepted id excluded, the pointer equal to the accepted id, and the count plus one checked against MAX_OUTSTANDING. If a winner exists, load it and stay in OFFER (back-to-back issue). Otherwise go to IDLE.
- Completion:
  - If `done_en` is set, `done_wf_id` < 40, and `pending[done_wf_id]` = 1: clear that bit and decrement the count.
  - Otherwise, when `done_en` is set: ignore the report and set `err_spurious_done`. It clears only on rst.
- Simultaneous accept and done:
  - Different ids: both take effect and the net count is unchanged.
  - Same id: the done is spurious, because the id is not yet pending.
- Completion is visible to selection in the following cycle, not the same cycle.
- `outstanding_cnt` always equals the popcount of `pending_arry`. It never exceeds MAX_OUTSTANDING and never underflows.

## Timing
- Reset values: `issue_valid` 0, `issue_wf_id` 0, `pending_arry` 0, `outstanding_cnt` 0, `err_spurious_done` 0, internal `last_issued` 39, state IDLE.
- The asynchronous reset mid-offer drops `issue_valid` immediately and does not complete the handshake.
- Latency:
  - From cand becoming non-zero (in IDLE, with room) to `issue_valid` high: 1 cycle.
  - From accept to the next offer: 0 cycles when a candidate and room exist.
  - From done to reissuing the same wavefront: at least 2 cycles.
- Sustained throughput: one issue per cycle while `fu_ready` stays high and candidates and capacity exist.
- Count at MAX_OUTSTANDING: no new offer. An offer already held in OFFER was selected with room, so its acceptance is always legal.

## Test plan
- Reset, then `ready_arry` = 40'h1 and `fu_ready` = 1 → `issue_valid` rises 1 cycle later with id 0; `pending_arry` = 40'h1 and `outstanding_cnt` = 1 after accept; no reissue of id 0.
- `ready_arry` = all ones, `fu_ready` = 1, MAX_OUTSTANDING = 8 → ids 0..7 issued on consecutive cycles, then `issue_valid` = 0. A done for id 3 → id 8 offered 2 cycles after the done.
- Fairness/wrap: `last_issued` = 38 and cand = bits {2, 39} → id 39 offered, then id 2.
- Hold: offer id 5 with `fu_ready` low for 4 cycles while `ready_arry[5]` drops → `issue_valid` and id 5 stay stable; accepted on the first `fu_ready` high.
- Spurious: done for id 10 while not pending, and done for id 45 → `err_spurious_done` = 1; `pending_arry` and `outstanding_cnt` unchanged.
- Accept id 4 and done id 1 in the same cycle with count 3 → count stays 3, bit 4 set, bit 1 cleared. Assert rst mid-offer → all outputs return to reset values asynchronously.
